// File: rtl/sysid_pkg.sv
// Shared constants for the system-ID / uptime register file: word addresses,
// CONTROL bit positions and the capability word builder.
package sysid_pkg;

  localparam int unsigned DATA_W = 32;

  localparam int unsigned ADDR_SYSID   = 0;
  localparam int unsigned ADDR_TSTAMP  = 1;
  localparam int unsigned ADDR_VERSION = 2;
  localparam int unsigned ADDR_CAPS    = 3;
  localparam int unsigned ADDR_UP_LO   = 4;
  localparam int unsigned ADDR_UP_HI   = 5;
  localparam int unsigned ADDR_SCRATCH = 6;
  localparam int unsigned ADDR_CTRL    = 7;

  localparam int unsigned CTRL_CLEAR  = 0;
  localparam int unsigned CTRL_FREEZE = 1;

  // CAPABILITY word: [7:0] counter width, [23:8] prescale, [31:24] zero
  function automatic logic [DATA_W-1:0] caps_word(input int unsigned cnt_w,
                                                  input int unsigned prescale);
    return {8'h00, 16'(prescale), 8'(cnt_w)};
  endfunction

endpackage

// File: rtl/sysid_uptime_qsys_if.sv
// Avalon-MM slave bus (no waitrequest) between the interconnect and the sysid block.
interface sysid_uptime_qsys_if #(
  parameter int unsigned ADDR_W = 3
);
  import sysid_pkg::*;

  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;

  modport master (
    output address, read, write, writedata,
    input  readdata, readdatavalid
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata, readdatavalid
  );

endinterface

// File: rtl/sysid_uptime_counter.sv
// Free-running uptime counter behind a 0..PRESCALE-1 prescaler, with
// synchronous clear and a freeze that holds both counters.
module sysid_uptime_counter #(
  parameter int unsigned CNT_W    = 64,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             freeze,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]  ps_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tick_c;

  assign tick_c = (ps_q == PS_W'(PRESCALE - 1));

  // Clear wins over a coincident tick; freeze holds the prescale phase too
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps_q  <= '0;
      cnt_q <= '0;
    end else if (clear) begin
      ps_q  <= '0;
      cnt_q <= '0;
    end else if (!freeze) begin
      ps_q <= tick_c ? '0 : ps_q + PS_W'(1);
      if (tick_c) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign count = cnt_q;

endmodule

// File: rtl/sysid_uptime_qsys.sv
// Registered system-ID register file: constants, uptime with atomic hi/lo
// snapshot, scratch and control, served with one-cycle read latency.
module sysid_uptime_qsys
  import sysid_pkg::*;
#(
  parameter logic [31:0] SYSTEM_ID = 32'h11223344,
  parameter logic [31:0] TIMESTAMP = 32'd1459255876,
  parameter logic [31:0] VERSION   = 32'h00010000,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned CNT_W     = 64,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  sysid_uptime_qsys_if.slave  bus
);

  localparam int unsigned HI_W = CNT_W - 32;

  logic [CNT_W-1:0]  count;
  logic [HI_W-1:0]   shadow_q;
  logic [DATA_W-1:0] scratch_q;
  logic              freeze_q;
  logic [DATA_W-1:0] readdata_q;
  logic              readdatavalid_q;

  logic              rd_c;
  logic              wr_c;
  logic              clear_c;
  logic [DATA_W-1:0] rdata_c;

  // A write coincident with a read is dropped
  assign rd_c    = bus.read;
  assign wr_c    = bus.write && !bus.read;
  assign clear_c = wr_c && (bus.address == ADDR_W'(ADDR_CTRL)) && bus.writedata[CTRL_CLEAR];

  sysid_uptime_counter #(
    .CNT_W    (CNT_W),
    .PRESCALE (PRESCALE)
  ) u_counter (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (clear_c),
    .freeze  (freeze_q),
    .count   (count)
  );

  // Read mux; unmapped addresses return zero
  always_comb begin
    rdata_c = '0;
    case (bus.address)
      ADDR_W'(ADDR_SYSID):   rdata_c = SYSTEM_ID;
      ADDR_W'(ADDR_TSTAMP):  rdata_c = TIMESTAMP;
      ADDR_W'(ADDR_VERSION): rdata_c = VERSION;
      ADDR_W'(ADDR_CAPS):    rdata_c = caps_word(CNT_W, PRESCALE);
      ADDR_W'(ADDR_UP_LO):   rdata_c = count[31:0];
      ADDR_W'(ADDR_UP_HI):   rdata_c = 32'(shadow_q);
      ADDR_W'(ADDR_SCRATCH): rdata_c = scratch_q;
      ADDR_W'(ADDR_CTRL):    rdata_c[CTRL_FREEZE] = freeze_q;
      default:               rdata_c = '0;
    endcase
  end

  // Read pipeline and hi shadow: the LO read captures both halves of one count value
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
      shadow_q        <= '0;
    end else begin
      readdatavalid_q <= rd_c;
      if (rd_c) begin
        readdata_q <= rdata_c;
      end
      if (rd_c && (bus.address == ADDR_W'(ADDR_UP_LO))) begin
        shadow_q <= count[CNT_W-1:32];
      end
    end
  end

  // Writable registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q <= '0;
      freeze_q  <= 1'b0;
    end else if (wr_c) begin
      if (bus.address == ADDR_W'(ADDR_SCRATCH)) begin
        scratch_q <= bus.writedata;
      end
      if (bus.address == ADDR_W'(ADDR_CTRL)) begin
        freeze_q <= bus.writedata[CTRL_FREEZE];
      end
    end
  end

  assign bus.readdata      = readdata_q;
  assign bus.readdatavalid = readdatavalid_q;

endmodule
